alu_exec_unit: RTL and testbench

//  Parametrised MIPS execute unit: decodes ALUOp/func, runs the operation and returns a registered result.

---
 rtl/alu_exec_unit.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//   MIPS execute stage. Decodes ALUOp/func, computes single-cycle operations in
//   one pass and runs MULT/MULTU/DIV/DIVU iteratively (one bit per cycle) into
//   the internal HI/LO pair. Valid/ready handshakes on both sides allow stalls.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   upstream handshake (transfer when both high)
//   alu_op, func, shamt   operation select and SLL shift amount
//   src_a, src_b          operands (captured at accept)
//   out_valid / out_ready downstream handshake (result held until accepted)
//   result, zero          registered result and its zero flag
//   overflow              signed overflow of R-type ADD/SUB
//   illegal               undecodable operation (result forced to 0)
//   busy                  iterative multiply/divide in progress
// -----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH         = 32,
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               alu_op,
    input  logic [5:0]               func,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [WIDTH-1:0]         src_a,
    input  logic [WIDTH-1:0]         src_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         result,
    output logic                     zero,
    output logic                     overflow,
    output logic                     illegal,
    output logic                     busy
);
    localparam int SHW = $clog2(WIDTH);
    // WIDTH is a power of two, so the last iteration index is all ones.
    localparam logic [SHW-1:0] CNT_LAST = '1;

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    // Iteration working registers: rem_q is the upper half (partial product /
    // partial remainder), quo_q the lower half (multiplier / quotient bits).
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
    logic [WIDTH-1:0] b_q, b_d;         // operand magnitude (multiplicand / divisor)
    logic [WIDTH-1:0] a_q, a_d;         // raw dividend, returned as HI on divide by zero
    logic             neg_res_q, neg_res_d;  // negate product / quotient at the end
    logic             neg_rem_q, neg_rem_d;  // remainder takes the dividend's sign
    logic             divz_q, divz_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;

    logic             accept;
    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] op_res;
    logic             op_ovf, op_ill, start_mul, start_div, op_signed;
    logic [WIDTH-1:0] mag_a, mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_rem, mul_quo;
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub, div_rem, div_quo, quo_fix, rem_fix;

    assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign illegal   = ill_q;

    assign sum  = src_a + src_b;
    assign diff = src_a - src_b;

    // Operation decode for the cycle of acceptance.
    always_comb begin
        op_res    = '0;
        op_ovf    = 1'b0;
        op_ill    = 1'b0;
        start_mul = 1'b0;
        start_div = 1'b0;
        op_signed = 1'b0;
        case (alu_op)
            2'b00: op_res = sum;
            2'b01: op_res = diff;
            2'b10: begin
                case (func)
                    F_AND:  op_res = src_a & src_b;
                    F_OR:   op_res = src_a | src_b;
                    F_ADD: begin
                        op_res = sum;
                        op_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                                 (sum[WIDTH-1] != src_a[WIDTH-1]);
                    end
                    F_ADDU: op_res = sum;
                    F_SUB: begin
                        op_res = diff;
                        op_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                                 (diff[WIDTH-1] != src_a[WIDTH-1]);
                    end
                    F_SUBU: op_res = diff;
                    F_SLT:  op_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
                    F_SLTU: op_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
                    F_SLL:  op_res = src_b << shamt;
                    F_MFHI: begin
                        if (ENABLE_MULDIV) op_res = hi_q;
                        else               op_ill = 1'b1;
                    end
                    F_MFLO: begin
                        if (ENABLE_MULDIV) op_res = lo_q;
                        else               op_ill = 1'b1;
                    end
                    F_MULT, F_MULTU: begin
                        if (ENABLE_MULDIV) begin
                            start_mul = 1'b1;
                            op_signed = (func == F_MULT);
                        end else begin
                            op_ill = 1'b1;
                        end
                    end
                    F_DIV, F_DIVU: begin
                        if (ENABLE_MULDIV) begin
                            start_div = 1'b1;
                            op_signed = (func == F_DIV);
                        end else begin
                            op_ill = 1'b1;
                        end
                    end
                    default: op_ill = 1'b1;
                endcase
            end
            default: op_ill = 1'b1;
        endcase
    end

    // Signed operations run on magnitudes; the sign is restored at completion.
    assign mag_a = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign mag_b = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    // One shift-add multiply step: add multiplicand if the current multiplier
    // bit is set, then shift the whole {rem,quo} pair right by one.
    assign mul_sum  = {1'b0, rem_q} + (quo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    assign mul_rem  = mul_sum[WIDTH:1];
    assign mul_quo  = {mul_sum[0], quo_q[WIDTH-1:1]};
    assign prod_mag = {mul_rem, mul_quo};
    assign prod_fix = neg_res_q ? -prod_mag : prod_mag;

    // One restoring-division step: shift in the next dividend bit and subtract
    // the divisor when it fits. The difference is below the divisor, so WIDTH
    // bits hold it exactly.
    assign div_trial = {rem_q, quo_q[WIDTH-1]};
    assign div_ge    = (div_trial >= {1'b0, b_q});
    assign div_sub   = div_trial[WIDTH-1:0] - b_q;
    assign div_rem   = div_ge ? div_sub : div_trial[WIDTH-1:0];
    assign div_quo   = {quo_q[WIDTH-2:0], div_ge};
    assign quo_fix   = divz_q ? '1   : (neg_res_q ? -div_quo : div_quo);
    assign rem_fix   = divz_q ? a_q  : (neg_rem_q ? -div_rem : div_rem);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        b_d         = b_q;
        a_d         = a_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        divz_d      = divz_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        ill_d       = ill_q;

        // Consumer took the current result; a new load below overrides this.
        if (out_ready) out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (start_mul || start_div) begin
                        state_d   = start_mul ? S_MUL : S_DIV;
                        count_d   = '0;
                        rem_d     = '0;
                        quo_d     = mag_a;
                        b_d       = mag_b;
                        a_d       = src_a;
                        neg_res_d = op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        neg_rem_d = op_signed && src_a[WIDTH-1];
                        divz_d    = (src_b == '0);
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = op_res;
                        zero_d      = (op_res == '0);
                        ovf_d       = op_ovf;
                        ill_d       = op_ill;
                    end
                end
            end
            S_MUL: begin
                count_d = count_q + 1'b1;
                rem_d   = mul_rem;
                quo_d   = mul_quo;
                if (count_q == CNT_LAST) begin
                    state_d     = S_IDLE;
                    count_d     = '0;
                    hi_d        = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d        = prod_fix[WIDTH-1:0];
                    out_valid_d = 1'b1;
                    result_d    = prod_fix[WIDTH-1:0];
                    zero_d      = (prod_fix[WIDTH-1:0] == '0);
                    ovf_d       = 1'b0;
                    ill_d       = 1'b0;
                end
            end
            S_DIV: begin
                count_d = count_q + 1'b1;
                rem_d   = div_rem;
                quo_d   = div_quo;
                if (count_q == CNT_LAST) begin
                    state_d     = S_IDLE;
                    count_d     = '0;
                    hi_d        = rem_fix;
                    lo_d        = quo_fix;
                    out_valid_d = 1'b1;
                    result_d    = quo_fix;
                    zero_d      = (quo_fix == '0);
                    ovf_d       = 1'b0;
                    ill_d       = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            b_q         <= '0;
            a_q         <= '0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            divz_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            b_q         <= b_d;
            a_q         <= a_d;
            neg_res_q   <= neg_res_d;
            neg_rem_q   <= neg_rem_d;
            divz_q      <= divz_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            ill_q       <= ill_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
//   Table-driven vectors for single-cycle ops, hand sequences for the
//   iterative, back-pressure and reset corner cases. Expected outputs are
//   queued when stimulus is driven and compared when the DUT hands a result
//   over (out_valid && out_ready).
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam int NVEC = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  alu_op = 2'b00;
    logic [5:0]  func = 6'b0;
    logic [4:0]  shamt = 5'd0;
    logic [31:0] src_a = 32'h0;
    logic [31:0] src_b = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero, overflow, illegal, busy;

    alu_exec_unit #(.WIDTH(32), .ENABLE_MULDIV(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .func(func), .shamt(shamt),
        .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .overflow(overflow),
        .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z, v, il;
        int          id;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [31:0] a, b, res;
        logic        z, v, il;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[NVEC];
    int   total = 0;
    int   bad = 0;
    int   next_id = 0;

    function automatic vec_t mk(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                                input logic z, input logic v, input logic il);
        vec_t t;
        t.op = op; t.fn = fn; t.sh = sh; t.a = a; t.b = b;
        t.res = res; t.z = z; t.v = v; t.il = il;
        return t;
    endfunction

    // Scoreboard: compare on every handshake at the falling edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output got result=%h with no pending expectation", result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (result !== e.res || zero !== e.z || overflow !== e.v || illegal !== e.il) begin
                    bad++;
                    $display("FAIL txn%0d got res=%h z=%b v=%b il=%b required res=%h z=%b v=%b il=%b",
                             e.id, result, zero, overflow, illegal, e.res, e.z, e.v, e.il);
                end else begin
                    $display("txn%0d ok res=%h z=%b v=%b il=%b", e.id, result, zero, overflow, illegal);
                end
            end
        end
    end

    // Drive one operation starting at posedge+1; returns at posedge+1 after accept.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                         input logic ez, input logic ev, input logic eil, input bit push);
        bit   acc;
        exp_t e;
        acc = 1'b0;
        alu_op = op; func = fn; shamt = sh; src_a = a; src_b = b; in_valid = 1'b1;
        if (push) begin
            e.res = er; e.z = ez; e.v = ev; e.il = eil; e.id = next_id;
            next_id++;
            exp_q.push_back(e);
        end
        for (int c = 0; c < 300 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        src_a = 32'hDEAD_BEEF;  // operands must already be captured
        src_b = 32'hDEAD_BEEF;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL accept got in_ready=0 for 300 cycles required 1");
        end
    endtask

    // Falling edges from the accept edge until out_valid; flags in_ready=1 or
    // busy=0 seen while waiting.
    task automatic measure(output int n, output bit hold_bad);
        n = 0;
        hold_bad = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
            if (in_ready !== 1'b0 || busy !== 1'b1) hold_bad = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending results required 0", exp_q.size());
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got %h required %h", name, got, req);
        end else begin
            $display("%s ok value=%h", name, got);
        end
    endtask

    initial begin
        int n;
        bit hb;

        vecs[0]  = mk(2'b10, F_ADD,  5'd0,  32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        vecs[1]  = mk(2'b10, F_ADDU, 5'd0,  32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(2'b10, F_SLT,  5'd0,  32'hFFFF_FFFF, 32'h1, 32'h1,         1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(2'b10, F_SLTU, 5'd0,  32'hFFFF_FFFF, 32'h1, 32'h0,         1'b1, 1'b0, 1'b0);
        vecs[4]  = mk(2'b10, F_SLL,  5'd31, 32'h1234,      32'h1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(2'b10, F_SUB,  5'd0,  32'h5,         32'h5, 32'h0,         1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(2'b10, F_SUB,  5'd0,  32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        vecs[7]  = mk(2'b10, F_SUBU, 5'd0,  32'h3,         32'h5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(2'b10, F_AND,  5'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(2'b10, F_OR,   5'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(2'b00, F_AND,  5'd0,  32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(2'b01, F_AND,  5'd0,  32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(2'b11, F_ADD,  5'd0,  32'h5,         32'h5, 32'h0,         1'b1, 1'b0, 1'b1);
        vecs[13] = mk(2'b10, 6'b100111, 5'd0, 32'h5,       32'h5, 32'h0,         1'b1, 1'b0, 1'b1);
        vecs[14] = mk(2'b10, F_SLT,  5'd0,  32'h1, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 1'b0);
        vecs[15] = mk(2'b10, F_SLTU, 5'd0,  32'h1, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0);
        vecs[16] = mk(2'b10, F_ADD,  5'd0,  32'hFFFF_FFFF, 32'h1, 32'h0,         1'b1, 1'b0, 1'b0);
        vecs[17] = mk(2'b10, F_SLL,  5'd4,  32'h0,         32'h3, 32'h30,        1'b0, 1'b0, 1'b0);

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {25'h0, out_valid, result, zero, overflow, illegal, busy, in_ready},
              {25'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-cycle latency
        issue(2'b10, F_ADD, 5'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        measure(n, hb);
        check("add_latency", 64'(n), 64'd1);

        // Table, issued back to back
        for (int i = 0; i < NVEC; i++)
            issue(vecs[i].op, vecs[i].fn, vecs[i].sh, vecs[i].a, vecs[i].b,
                  vecs[i].res, vecs[i].z, vecs[i].v, vecs[i].il, 1'b1);
        drain();

        // Iterative ops
        issue(2'b10, F_MULT, 5'd0, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFA, 1'b0, 1'b0, 1'b0, 1'b1);
        measure(n, hb);
        check("mult_latency", 64'(n), 64'd33);
        check("mult_stall_ready_busy", 64'(hb), 64'd0);
        issue(2'b10, F_MFHI, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(2'b10, F_MFLO, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFA, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(2'b10, F_DIV,  5'd0, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(2'b10, F_MFHI, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(2'b10, F_DIV,  5'd0, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(2'b10, F_MFHI, 5'd0, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(2'b10, F_DIVU, 5'd0, 32'h7, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(2'b10, F_MFHI, 5'd0, 32'h0, 32'h0, 32'h7, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(2'b10, F_DIV,  5'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(2'b10, F_MFHI, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(2'b10, F_MULTU, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(2'b10, F_MFHI, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        // Back-pressure: first result held three cycles, second op waits
        out_ready = 1'b0;
        issue(2'b00, F_AND, 5'd0, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1'b0, 1'b1);
        fork
            issue(2'b10, F_SUBU, 5'd0, 32'hA, 32'h4, 32'h6, 1'b0, 1'b0, 1'b0, 1'b1);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("backpressure_hold", {30'h0, out_valid, in_ready, result},
                          {30'h0, 1'b1, 1'b0, 32'h3});
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset in cycle 10 of a DIVU: everything clears, HI/LO included
        issue(2'b10, F_DIVU, 5'd0, 32'd100, 32'd3, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #2;
        check("div_busy_before_reset", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("reset_mid_div",
              {26'h0, out_valid, result, zero, overflow, illegal, busy},
              {26'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(2'b10, F_MFLO, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(2'b10, F_MFHI, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
